deadlock_report_ctrl: RTL and testbench

Consumer end of the dataflow deadlock monitors: it takes the per-region `block` outputs of the monitors plus the raw per-process idle/channel-block/axis-block vectors. It debounces a monitor block into a confirmed deadlock, timestamps it and snapshots the process state. It then streams a fixed 3-beat report over a valid/ready interface to the testbench/debug sink. It holds a sticky deadlock flag until cleared.

---
 rtl/deadlock_report_ctrl_if.sv | 29 ++
 rtl/deadlock_report_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_deadlock_report_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deadlock_report_ctrl_if.sv
// deadlock_report_ctrl_if
// Report stream between the deadlock report controller and its debug sink.
// A beat moves on a rising clock edge where report_valid && report_ready.
//   report_valid  : beat valid (driven by master)
//   report_ready  : sink accepts beat (driven by slave)
//   report_data   : 32-bit beat payload (driven by master)
//   report_last   : high on the final beat of a report (driven by master)
interface deadlock_report_ctrl_if;

    logic        report_valid;
    logic        report_ready;
    logic [31:0] report_data;
    logic        report_last;

    modport master (
        output report_valid,
        output report_data,
        output report_last,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_data,
        input  report_last,
        output report_ready
    );

endinterface

// File: rtl/deadlock_report_ctrl.sv
// deadlock_report_ctrl
// Consumer end of the dataflow deadlock monitors. A monitor block that
// persists for PERSIST_CYCLES consecutive cycles is confirmed as a deadlock:
// the onset cycle is timestamped, the per-process state is snapshotted and a
// 3-beat report is streamed to the debug sink. A sticky flag records the
// deadlock until clear.
//
// Ports:
//   clock           : single clock, all state on rising edge
//   reset           : asynchronous active-high reset
//   mon_block       : block outputs of the deadlock monitors
//   proc_idle       : per-process idle
//   proc_chan_block : per-process channel block
//   proc_axis_block : per-process axis block
//   clear           : synchronous pulse, drops the sticky flag and rearms
//   report          : report stream (master side of deadlock_report_ctrl_if)
//   deadlock_flag   : sticky confirmed-deadlock indicator
//   cycle_count     : free-running cycle counter
//
// Report beats:
//   0 : onset timestamp
//   1 : {mon snapshot, idle snapshot}, each zero-extended to 16 bits
//   2 : {axis snapshot, chan snapshot}, each zero-extended to 16 bits, last
//
// Build option:
//   DEADLOCK_RETRIGGER_EN : when defined, a finished report rearms by itself
//   once every monitor block has been low for one cycle (flag stays sticky).
//   When undefined, only clear or reset rearms the controller.
module deadlock_report_ctrl #(
    parameter int unsigned NUM_MON        = 2,
    parameter int unsigned NUM_PROC       = 6,
    parameter int unsigned PERSIST_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_MON-1:0]      mon_block,
    input  logic [NUM_PROC-1:0]     proc_idle,
    input  logic [NUM_PROC-1:0]     proc_chan_block,
    input  logic [NUM_PROC-1:0]     proc_axis_block,
    input  logic                    clear,
    deadlock_report_ctrl_if.master  report,
    output logic                    deadlock_flag,
    output logic [31:0]             cycle_count
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BEAT_W = 2;

    localparam logic [CNT_W-1:0]  PERSIST_LAST = CNT_W'(PERSIST_CYCLES);
    localparam logic [BEAT_W-1:0] BEAT_ONSET   = BEAT_W'(0);
    localparam logic [BEAT_W-1:0] BEAT_MON     = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_PROC    = BEAT_W'(2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [CNT_W-1:0]       persist_q, persist_d;
    logic [DATA_W-1:0]      onset_q, onset_d;
    logic [NUM_MON-1:0]     mon_snap_q, mon_snap_d;
    logic [NUM_PROC-1:0]    idle_snap_q, idle_snap_d;
    logic [NUM_PROC-1:0]    chan_snap_q, chan_snap_d;
    logic [NUM_PROC-1:0]    axis_snap_q, axis_snap_d;
    logic                   valid_q, valid_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   last_q, last_d;
    logic                   flag_q, flag_d;

    logic                   any_blk;
    logic                   xfer;
    logic [DATA_W-1:0]      mon_word;
    logic [DATA_W-1:0]      proc_word;

    assign any_blk = |mon_block;
    assign xfer    = valid_q && report.report_ready;

    // Snapshot payloads; unused upper bits of each half read as zero.
    assign mon_word  = {HALF_W'(mon_snap_q),  HALF_W'(idle_snap_q)};
    assign proc_word = {HALF_W'(axis_snap_q), HALF_W'(chan_snap_q)};

    assign report.report_valid = valid_q;
    assign report.report_data  = data_q;
    assign report.report_last  = last_q;
    assign deadlock_flag       = flag_q;

    // Free-running timestamp base, wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + DATA_W'(1);
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            persist_q   <= '0;
            onset_q     <= '0;
            mon_snap_q  <= '0;
            idle_snap_q <= '0;
            chan_snap_q <= '0;
            axis_snap_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            persist_q   <= persist_d;
            onset_q     <= onset_d;
            mon_snap_q  <= mon_snap_d;
            idle_snap_q <= idle_snap_d;
            chan_snap_q <= chan_snap_d;
            axis_snap_q <= axis_snap_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
            flag_q      <= flag_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        persist_d   = persist_q;
        onset_d     = onset_q;
        mon_snap_d  = mon_snap_q;
        idle_snap_d = idle_snap_q;
        chan_snap_d = chan_snap_q;
        axis_snap_d = axis_snap_q;
        valid_d     = valid_q;
        data_d      = data_q;
        last_d      = last_q;
        flag_d      = flag_q;

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    persist_d = '0;
                    flag_d    = 1'b0;
                end else if (any_blk) begin
                    // Onset is the first cycle the block is seen.
                    onset_d   = cycle_count;
                    persist_d = CNT_W'(1);
                    if (PERSIST_CYCLES == 1) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end

            ST_ARMED: begin
                if (clear) begin
                    persist_d = '0;
                    flag_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (!any_blk) begin
                    // Block did not persist: drop it silently.
                    persist_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    persist_d = persist_q + CNT_W'(1);
                    if (persist_d == PERSIST_LAST) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                mon_snap_d  = mon_block;
                idle_snap_d = proc_idle;
                chan_snap_d = proc_chan_block;
                axis_snap_d = proc_axis_block;
                persist_d   = '0;
                flag_d      = 1'b1;
                beat_d      = BEAT_ONSET;
                valid_d     = 1'b1;
                data_d      = onset_q;
                last_d      = 1'b0;
                state_d     = ST_SEND;
            end

            ST_SEND: begin
                // Payload only advances on a transfer, so it holds while stalled.
                if (xfer) begin
                    case (beat_q)
                        BEAT_ONSET: begin
                            beat_d = BEAT_MON;
                            data_d = mon_word;
                        end
                        BEAT_MON: begin
                            beat_d = BEAT_PROC;
                            data_d = proc_word;
                            last_d = 1'b1;
                        end
                        default: begin
                            beat_d  = BEAT_ONSET;
                            valid_d = 1'b0;
                            data_d  = '0;
                            last_d  = 1'b0;
                            // A clear landing on the final transfer rearms at once.
                            if (clear) begin
                                flag_d  = 1'b0;
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    endcase
                end
            end

            ST_DONE: begin
                if (clear) begin
                    persist_d = '0;
                    flag_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
`ifdef DEADLOCK_RETRIGGER_EN
                else if (!any_blk) begin
                    // Block released: rearm for a further report, flag stays set.
                    state_d = ST_IDLE;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_deadlock_report_ctrl.sv
// tb_deadlock_report_ctrl
// Self-checking bench for deadlock_report_ctrl. Stimulus is driven on the
// falling edge; outputs are sampled on the falling edge as well. Expected
// report words come from a small model of the report format and the bench's
// own cycle counter.
module tb_deadlock_report_ctrl;

    localparam int unsigned NUM_MON  = 2;
    localparam int unsigned NUM_PROC = 6;
    localparam int unsigned P        = 16;
    localparam int unsigned CNT_W    = 8;

    logic                clock;
    logic                reset;
    logic [NUM_MON-1:0]  mon_block;
    logic [NUM_PROC-1:0] proc_idle;
    logic [NUM_PROC-1:0] proc_chan_block;
    logic [NUM_PROC-1:0] proc_axis_block;
    logic                clear;
    logic                report_ready;
    logic                deadlock_flag;
    logic [31:0]         cycle_count;

    int n_pass;
    int n_total;
    int model_cnt;

    deadlock_report_ctrl_if rif ();
    assign rif.report_ready = report_ready;

    deadlock_report_ctrl #(
        .NUM_MON        (NUM_MON),
        .NUM_PROC       (NUM_PROC),
        .PERSIST_CYCLES (P),
        .CNT_W          (CNT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mon_block       (mon_block),
        .proc_idle       (proc_idle),
        .proc_chan_block (proc_chan_block),
        .proc_axis_block (proc_axis_block),
        .clear           (clear),
        .report          (rif),
        .deadlock_flag   (deadlock_flag),
        .cycle_count     (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference cycle counter: cycles elapsed since reset released.
    always @(posedge clock or posedge reset) begin
        if (reset) model_cnt <= 0;
        else       model_cnt <= model_cnt + 1;
    end

    // Report format model: beat 0 timestamp, beat 1 monitors/idle, beat 2 axis/chan.
    function automatic logic [31:0] model_beat(input int k, input int onset,
                                               input int mon, input int idle,
                                               input int chan, input int axis);
        case (k)
            0:       return 32'(onset);
            1:       return 32'(mon * 65536 + idle);
            default: return 32'(axis * 65536 + chan);
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset           = 1'b1;
        mon_block       = '0;
        proc_idle       = '0;
        proc_chan_block = '0;
        proc_axis_block = '0;
        clear           = 1'b0;
        report_ready    = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Gathers one report. mode 0: always ready, 1: two stalls per beat,
    // 2: random ready. clr_beat: beat index during whose valid cycles clear is high.
    task automatic collect(input int mode, input int clr_beat,
                           output logic [2:0][31:0] d, output logic [2:0] l,
                           output int n_xfer, output int unstable,
                           output int first_cc, output logic flag_first);
        int          stall;
        logic        prev_stalled;
        logic [31:0] prev_d;
        logic        prev_l;
        logic        rdy;
        n_xfer = 0; unstable = 0; first_cc = -1; flag_first = 1'b0;
        stall = 0; prev_stalled = 1'b0; prev_d = '0; prev_l = 1'b0;
        d = '0; l = '0;
        for (int c = 0; c < 300 && n_xfer < 3; c++) begin
            @(negedge clock);
            if (rif.report_valid) begin
                if (first_cc < 0) begin
                    first_cc   = int'(cycle_count);
                    flag_first = deadlock_flag;
                end
                if (prev_stalled && (rif.report_data !== prev_d || rif.report_last !== prev_l))
                    unstable++;
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = (stall >= 2);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                report_ready = rdy;
                clear        = (n_xfer == clr_beat);
                if (rdy) begin
                    d[n_xfer]    = rif.report_data;
                    l[n_xfer]    = rif.report_last;
                    n_xfer++;
                    stall        = 0;
                    prev_stalled = 1'b0;
                end else begin
                    stall++;
                    prev_stalled = 1'b1;
                    prev_d       = rif.report_data;
                    prev_l       = rif.report_last;
                end
            end else begin
                if (prev_stalled) unstable++;
                prev_stalled = 1'b0;
                clear        = 1'b0;
                report_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        #1;
        n_total++; if (rif.report_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rif.report_valid); else n_pass++;
        n_total++; if (rif.report_data !== 32'h0) $display("FAIL reset_data: got %h expected 0", rif.report_data); else n_pass++;
        n_total++; if (rif.report_last !== 1'b0) $display("FAIL reset_last: got %b expected 0", rif.report_last); else n_pass++;
        n_total++; if (deadlock_flag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", deadlock_flag); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        n_total++; if (cycle_count !== 32'd0) $display("FAIL reset_count: got %0d expected 0", cycle_count); else n_pass++;
        repeat (3) @(negedge clock);
        n_total++; if (cycle_count !== 32'd3) $display("FAIL count_run: got %0d expected 3", cycle_count); else n_pass++;
    endtask

    task automatic test_directed();
        logic [2:0][31:0] d;
        logic [2:0]       l;
        int               nx, uns, fcc;
        logic             ff;
        do_reset();
        while (model_cnt != 100) @(negedge clock);
        mon_block       = 2'b10;
        proc_idle       = 6'b101010;
        proc_chan_block = 6'b010101;
        proc_axis_block = 6'b100000;
        report_ready    = 1'b1;
        while (model_cnt != 115) @(negedge clock);
        n_total++; if (deadlock_flag !== 1'b0) $display("FAIL dir_flag_early: got %b expected 0", deadlock_flag); else n_pass++;
        collect(0, -1, d, l, nx, uns, fcc, ff);
        n_total++; if (nx !== 3) $display("FAIL dir_xfers: got %0d expected 3", nx); else n_pass++;
        n_total++; if (d[0] !== 32'h00000064) $display("FAIL dir_beat0: got %h expected 00000064", d[0]); else n_pass++;
        n_total++; if (d[1] !== 32'h0002002A) $display("FAIL dir_beat1: got %h expected 0002002a", d[1]); else n_pass++;
        n_total++; if (d[2] !== 32'h00200015) $display("FAIL dir_beat2: got %h expected 00200015", d[2]); else n_pass++;
        n_total++; if (l !== 3'b100) $display("FAIL dir_last: got %b expected 100", l); else n_pass++;
        n_total++; if (fcc !== 100 + P + 1) $display("FAIL dir_latency: got %0d expected %0d", fcc, 100 + P + 1); else n_pass++;
        n_total++; if (ff !== 1'b1) $display("FAIL dir_flag_set: got %b expected 1", ff); else n_pass++;
        @(negedge clock);
        n_total++; if (rif.report_valid !== 1'b0) $display("FAIL dir_valid_drop: got %b expected 0", rif.report_valid); else n_pass++;
        n_total++; if (deadlock_flag !== 1'b1) $display("FAIL dir_flag_hold: got %b expected 1", deadlock_flag); else n_pass++;
    endtask

    // Block released for one cycle then reasserted while a report is finished.
    task automatic test_done_hold();
        int onset;
        mon_block = '0;
        @(negedge clock);
        n_total++; if (deadlock_flag !== 1'b1) $display("FAIL done_flag_release: got %b expected 1", deadlock_flag); else n_pass++;
        mon_block = 2'b10;
        onset     = model_cnt;
`ifdef DEADLOCK_RETRIGGER_EN
        begin
            logic [2:0][31:0] d;
            logic [2:0]       l;
            int               nx, uns, fcc;
            logic             ff;
            collect(2, -1, d, l, nx, uns, fcc, ff);
            n_total++; if (nx !== 3) $display("FAIL retrig_xfers: got %0d expected 3", nx); else n_pass++;
            n_total++; if (d[0] !== model_beat(0, onset, 2, 42, 21, 32)) $display("FAIL retrig_beat0: got %h expected %h", d[0], model_beat(0, onset, 2, 42, 21, 32)); else n_pass++;
            n_total++; if (ff !== 1'b1) $display("FAIL retrig_flag: got %b expected 1", ff); else n_pass++;
        end
`else
        begin
            int seen;
            seen = 0;
            repeat (2 * P + 4) begin
                @(negedge clock);
                if (rif.report_valid) seen++;
            end
            n_total++; if (seen !== 0) $display("FAIL done_no_report: got %0d valid cycles expected 0", seen); else n_pass++;
            n_total++; if (deadlock_flag !== 1'b1) $display("FAIL done_flag_sticky: got %b expected 1", deadlock_flag); else n_pass++;
        end
`endif
        @(negedge clock);
        mon_block = '0;
        clear     = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        n_total++; if (deadlock_flag !== 1'b0) $display("FAIL done_clear_flag: got %b expected 0", deadlock_flag); else n_pass++;
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        @(negedge clock);
        mon_block = 2'b01;
        repeat (5) @(negedge clock);
        mon_block = '0;
        repeat (P + 6) begin
            @(negedge clock);
            if (rif.report_valid) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL glitch_report: got %0d valid cycles expected 0", seen); else n_pass++;
        n_total++; if (deadlock_flag !== 1'b0) $display("FAIL glitch_flag: got %b expected 0", deadlock_flag); else n_pass++;
        n_total++; if (cycle_count !== 32'(model_cnt)) $display("FAIL glitch_count: got %0d expected %0d", cycle_count, model_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        logic [2:0][31:0] d;
        logic [2:0]       l;
        int               nx, uns, fcc, onset;
        logic             ff;
        @(negedge clock);
        mon_block       = 2'b10;
        proc_idle       = 6'b101010;
        proc_chan_block = 6'b010101;
        proc_axis_block = 6'b100000;
        onset           = model_cnt;
        collect(1, -1, d, l, nx, uns, fcc, ff);
        n_total++; if (nx !== 3) $display("FAIL stall_xfers: got %0d expected 3", nx); else n_pass++;
        n_total++; if (uns !== 0) $display("FAIL stall_stable: got %0d changes expected 0", uns); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (d[k] !== model_beat(k, onset, 2, 42, 21, 32)) $display("FAIL stall_beat%0d: got %h expected %h", k, d[k], model_beat(k, onset, 2, 42, 21, 32)); else n_pass++;
        end
        n_total++; if (l !== 3'b100) $display("FAIL stall_last: got %b expected 100", l); else n_pass++;
        @(negedge clock);
        report_ready = 1'b0;
        n_total++; if (rif.report_valid !== 1'b0) $display("FAIL stall_valid_drop: got %b expected 0", rif.report_valid); else n_pass++;
        mon_block = '0;
        clear     = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_clear();
        logic [2:0][31:0] d;
        logic [2:0]       l;
        int               nx, uns, fcc, onset;
        logic             ff;
        @(negedge clock);
        mon_block       = 2'b11;
        proc_idle       = 6'b000111;
        proc_chan_block = 6'b110000;
        proc_axis_block = 6'b001100;
        onset           = model_cnt;
        collect(0, 1, d, l, nx, uns, fcc, ff);
        n_total++; if (nx !== 3) $display("FAIL clrsend_xfers: got %0d expected 3", nx); else n_pass++;
        n_total++; if (d[2] !== model_beat(2, onset, 3, 7, 48, 12)) $display("FAIL clrsend_beat2: got %h expected %h", d[2], model_beat(2, onset, 3, 7, 48, 12)); else n_pass++;
        @(negedge clock);
        n_total++; if (deadlock_flag !== 1'b1) $display("FAIL clrsend_flag: got %b expected 1", deadlock_flag); else n_pass++;
        mon_block = '0;
        clear     = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        n_total++; if (deadlock_flag !== 1'b0) $display("FAIL clrdone_flag: got %b expected 0", deadlock_flag); else n_pass++;
        mon_block = 2'b01;
        onset     = model_cnt;
        collect(0, 2, d, l, nx, uns, fcc, ff);
        n_total++; if (nx !== 3) $display("FAIL second_xfers: got %0d expected 3", nx); else n_pass++;
        n_total++; if (d[0] !== model_beat(0, onset, 1, 7, 48, 12)) $display("FAIL second_beat0: got %h expected %h", d[0], model_beat(0, onset, 1, 7, 48, 12)); else n_pass++;
        n_total++; if (d[1] !== model_beat(1, onset, 1, 7, 48, 12)) $display("FAIL second_beat1: got %h expected %h", d[1], model_beat(1, onset, 1, 7, 48, 12)); else n_pass++;
        @(negedge clock);
        clear     = 1'b0;
        mon_block = '0;
        n_total++; if (deadlock_flag !== 1'b0) $display("FAIL clrlast_flag: got %b expected 0", deadlock_flag); else n_pass++;
        n_total++; if (rif.report_valid !== 1'b0) $display("FAIL clrlast_valid: got %b expected 0", rif.report_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [2:0][31:0] d;
        logic [2:0]       l;
        int               nx, uns, fcc, onset;
        logic             ff, got;
        @(negedge clock);
        mon_block       = 2'b10;
        proc_idle       = 6'b101010;
        proc_chan_block = 6'b010101;
        proc_axis_block = 6'b100000;
        report_ready    = 1'b0;
        onset           = model_cnt;
        got             = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clock);
            if (rif.report_valid) got = 1'b1;
        end
        report_ready = 1'b1;
        @(negedge clock);
        report_ready = 1'b0;
        n_total++; if (rif.report_data !== model_beat(1, onset, 2, 42, 21, 32)) $display("FAIL rmid_beat1: got %h expected %h", rif.report_data, model_beat(1, onset, 2, 42, 21, 32)); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (rif.report_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", rif.report_valid); else n_pass++;
        n_total++; if (rif.report_data !== 32'h0) $display("FAIL rmid_data: got %h expected 0", rif.report_data); else n_pass++;
        n_total++; if (deadlock_flag !== 1'b0) $display("FAIL rmid_flag: got %b expected 0", deadlock_flag); else n_pass++;
        n_total++; if (cycle_count !== 32'h0) $display("FAIL rmid_count: got %0d expected 0", cycle_count); else n_pass++;
        mon_block = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (7) @(negedge clock);
        mon_block = 2'b01;
        onset     = model_cnt;
        collect(2, -1, d, l, nx, uns, fcc, ff);
        n_total++; if (nx !== 3) $display("FAIL rfresh_xfers: got %0d expected 3", nx); else n_pass++;
        n_total++; if (d[0] !== 32'd7) $display("FAIL rfresh_onset: got %h expected 00000007", d[0]); else n_pass++;
        n_total++; if (d[2] !== model_beat(2, onset, 1, 42, 21, 32)) $display("FAIL rfresh_beat2: got %h expected %h", d[2], model_beat(2, onset, 1, 42, 21, 32)); else n_pass++;
        @(negedge clock);
        mon_block = '0;
        clear     = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0][31:0] d;
        logic [2:0]       l;
        int               nx, uns, fcc, onset, hold, mv, iv, cv, av, mode, seen;
        logic             ff;
        for (int it = 0; it < 12; it++) begin
            hold = $urandom_range(1, 2 * P);
            mv   = $urandom_range(1, 3);
            iv   = $urandom_range(0, 63);
            cv   = $urandom_range(0, 63);
            av   = $urandom_range(0, 63);
            mode = $urandom_range(0, 2);
            @(negedge clock);
            mon_block       = NUM_MON'(mv);
            proc_idle       = NUM_PROC'(iv);
            proc_chan_block = NUM_PROC'(cv);
            proc_axis_block = NUM_PROC'(av);
            onset           = model_cnt;
            if (hold < P) begin
                repeat (hold) @(negedge clock);
                mon_block = '0;
                seen      = 0;
                repeat (P + 4) begin
                    @(negedge clock);
                    if (rif.report_valid) seen++;
                end
                n_total++; if (seen !== 0) $display("FAIL rnd%0d_glitch: hold %0d got %0d valid cycles expected 0", it, hold, seen); else n_pass++;
                n_total++; if (deadlock_flag !== 1'b0) $display("FAIL rnd%0d_flag: got %b expected 0", it, deadlock_flag); else n_pass++;
            end else begin
                collect(mode, -1, d, l, nx, uns, fcc, ff);
                n_total++; if (nx !== 3) $display("FAIL rnd%0d_xfers: got %0d expected 3", it, nx); else n_pass++;
                n_total++; if (uns !== 0) $display("FAIL rnd%0d_stable: got %0d expected 0", it, uns); else n_pass++;
                n_total++; if (fcc !== onset + P + 1) $display("FAIL rnd%0d_latency: got %0d expected %0d", it, fcc, onset + P + 1); else n_pass++;
                for (int k = 0; k < 3; k++) begin
                    n_total++; if (d[k] !== model_beat(k, onset, mv, iv, cv, av)) $display("FAIL rnd%0d_beat%0d: got %h expected %h", it, k, d[k], model_beat(k, onset, mv, iv, cv, av)); else n_pass++;
                end
                n_total++; if (l !== 3'b100) $display("FAIL rnd%0d_last: got %b expected 100", it, l); else n_pass++;
                @(negedge clock);
                mon_block = '0;
                clear     = 1'b1;
                @(negedge clock);
                clear = 1'b0;
                n_total++; if (deadlock_flag !== 1'b0) $display("FAIL rnd%0d_clear: got %b expected 0", it, deadlock_flag); else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        reset           = 1'b0;
        mon_block       = '0;
        proc_idle       = '0;
        proc_chan_block = '0;
        proc_axis_block = '0;
        clear           = 1'b0;
        report_ready    = 1'b0;
        test_reset();
        test_directed();
        test_done_hold();
        test_glitch();
        test_stall();
        test_clear();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
